// File: rtl/endecoder_arb.sv
// Round-robin arbiter/sequencer sharing one endecoder_core between requesters A and B.
// Define ENDEC_ARB_STATS_EN to add saturating per-requester and timeout statistics counters.
module endecoder_arb #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       a_valid_i,
    output logic       a_ready_o,
    input  logic [3:0] a_code_i,
    input  logic [3:0] a_key_i,
    input  logic       a_mode_i,
    input  logic       b_valid_i,
    output logic       b_ready_o,
    input  logic [3:0] b_code_i,
    input  logic [3:0] b_key_i,
    input  logic       b_mode_i,
    output logic [3:0] core_code_o,
    output logic [3:0] core_key_o,
    output logic       core_mode_o,
    output logic       core_start_o,
    input  logic [3:0] core_code_i,
    input  logic       core_done_i,
    output logic       rsp_valid_o,
    input  logic       rsp_ready_i,
    output logic [3:0] rsp_code_o,
    output logic       rsp_id_o,
    output logic       rsp_err_o
`ifdef ENDEC_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0] stat_a_o,
    output logic [CNT_W-1:0] stat_b_o,
    output logic [CNT_W-1:0] stat_to_o
`endif
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    logic [1:0] state_q, state_d;
    logic       last_grant_q, last_grant_d;
    logic [3:0] core_code_q, core_code_d;
    logic [3:0] core_key_q, core_key_d;
    logic       core_mode_q, core_mode_d;
    logic [3:0] rsp_code_q, rsp_code_d;
    logic       rsp_id_q, rsp_id_d;
    logic       rsp_err_q, rsp_err_d;
    logic [7:0] cnt_q, cnt_d;
    logic       grant_a, grant_b, rsp_hs;

    // Ready is masked during reset so a held valid never looks accepted.
    assign grant_a = !rst_i && (state_q == IDLE) && a_valid_i && (!b_valid_i || last_grant_q);
    assign grant_b = !rst_i && (state_q == IDLE) && b_valid_i && (!a_valid_i || !last_grant_q);
    assign rsp_hs  = (state_q == RESP) && rsp_ready_i;

    assign a_ready_o    = grant_a;
    assign b_ready_o    = grant_b;
    assign core_code_o  = core_code_q;
    assign core_key_o   = core_key_q;
    assign core_mode_o  = core_mode_q;
    assign core_start_o = (state_q == ISSUE);
    assign rsp_valid_o  = (state_q == RESP);
    assign rsp_code_o   = rsp_code_q;
    assign rsp_id_o     = rsp_id_q;
    assign rsp_err_o    = rsp_err_q;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        core_code_d  = core_code_q;
        core_key_d   = core_key_q;
        core_mode_d  = core_mode_q;
        rsp_code_d   = rsp_code_q;
        rsp_id_d     = rsp_id_q;
        rsp_err_d    = rsp_err_q;
        cnt_d        = cnt_q;
        case (state_q)
            IDLE: begin
                if (grant_a) begin
                    core_code_d = a_code_i;
                    core_key_d  = a_key_i;
                    core_mode_d = a_mode_i;
                    rsp_id_d    = 1'b0;
                    state_d     = ISSUE;
                end else if (grant_b) begin
                    core_code_d = b_code_i;
                    core_key_d  = b_key_i;
                    core_mode_d = b_mode_i;
                    rsp_id_d    = 1'b1;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                cnt_d   = 8'(TIMEOUT_CYC - 1);
                state_d = WAIT;
            end
            WAIT: begin
                // A done arriving on the last allowed cycle still beats the timeout.
                if (core_done_i) begin
                    rsp_code_d = core_code_i;
                    rsp_err_d  = 1'b0;
                    state_d    = RESP;
                end else if (cnt_q == 8'd0) begin
                    rsp_code_d = 4'h0;
                    rsp_err_d  = 1'b1;
                    state_d    = RESP;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            RESP: begin
                if (rsp_ready_i) begin
                    last_grant_d = rsp_id_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            core_code_q  <= 4'h0;
            core_key_q   <= 4'h0;
            core_mode_q  <= 1'b0;
            rsp_code_q   <= 4'h0;
            rsp_id_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            cnt_q        <= 8'd0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            core_code_q  <= core_code_d;
            core_key_q   <= core_key_d;
            core_mode_q  <= core_mode_d;
            rsp_code_q   <= rsp_code_d;
            rsp_id_q     <= rsp_id_d;
            rsp_err_q    <= rsp_err_d;
            cnt_q        <= cnt_d;
        end
    end

`ifdef ENDEC_ARB_STATS_EN
    logic [CNT_W-1:0] stat_a_q, stat_b_q, stat_to_q;

    // Counters saturate at all-ones rather than wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stat_a_q  <= '0;
            stat_b_q  <= '0;
            stat_to_q <= '0;
        end else if (rsp_hs) begin
            if (!rsp_id_q && (stat_a_q != '1)) stat_a_q <= stat_a_q + CNT_W'(1);
            if (rsp_id_q && (stat_b_q != '1)) stat_b_q <= stat_b_q + CNT_W'(1);
            if (rsp_err_q && (stat_to_q != '1)) stat_to_q <= stat_to_q + CNT_W'(1);
        end
    end

    assign stat_a_o  = stat_a_q;
    assign stat_b_o  = stat_b_q;
    assign stat_to_o = stat_to_q;
`else
    logic unused_hs;
    assign unused_hs = rsp_hs;
`endif

endmodule

// File: doc/endecoder_arb.md
Name: endecoder_arb

Overview:
- Round-robin arbiter and sequencer that shares one endecoder_core between two requesters, A and B.
- Accepts one nibble job per grant over a valid/ready handshake and registers the core operands.
- Pulses the core start, waits for done with a timeout, and returns the result on a single tagged response channel.
- Sits between the user I/O mapping logic and endecoder_core.

Parameters:
- TIMEOUT_CYC, 16: WAIT cycles allowed for core_done_i before an error response; legal range 1..255.
- CNT_W, 8: width of the statistics counters; used only when ENDEC_ARB_STATS_EN is defined.

Ports:
- clk_i  in  1  single clock; all logic on rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- a_valid_i  in  1  requester A job valid.
- a_ready_o  out  1  requester A job accepted this cycle.
- a_code_i  in  4  requester A data nibble.
- a_key_i  in  4  requester A key nibble.
- a_mode_i  in  1  requester A mode: 0 = encrypt, 1 = decrypt.
- b_valid_i, b_ready_o, b_code_i, b_key_i, b_mode_i: same as A, for requester B.
- core_code_o  out  4  code operand to the core.
- core_key_o  out  4  key operand to the core.
- core_mode_o  out  1  mode operand to the core.
- core_start_o  out  1  one-cycle start pulse to the core.
- core_code_i  in  4  result from the core.
- core_done_i  in  1  core done.
- rsp_valid_o  out  1  response valid.
- rsp_ready_i  in  1  response consumer ready.
- rsp_code_o  out  4  result nibble.
- rsp_id_o  out  1  requester of this response: 0 = A, 1 = B.
- rsp_err_o  out  1  1 = the job timed out.

Behaviour:
- States: IDLE, ISSUE, WAIT, RESP. State after reset is IDLE.
- Reset values: all outputs 0; operand regs 0; last_grant = B, so A wins the first contention.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not equal to last_grant.
  - x_ready_o for the granted requester is combinational, high only in IDLE during the grant cycle.
  - On grant: capture code/key/mode into core_*_o regs and the grant id into rsp_id_o; go to ISSUE.
  - No valid: stay in IDLE.
- ISSUE:
  - core_start_o = 1 for exactly this cycle.
  - Load the timeout counter with TIMEOUT_CYC-1; go to WAIT.
  - core_done_i is ignored in ISSUE.
- WAIT:
  - core_done_i = 1: capture core_code_i into rsp_code_o, rsp_err_o = 0; go to RESP.
  - Else counter == 0: rsp_code_o = 0, rsp_err_o = 1; go to RESP.
  - Else: decrement the counter.
  - done and counter == 0 in the same cycle: done wins, no error.
- RESP:
  - rsp_valid_o = 1, with rsp_code_o, rsp_id_o and rsp_err_o stable until rsp_ready_i = 1.
  - On that handshake: last_grant = rsp_id_o; go to IDLE.
  - No new job is accepted until the next cycle.
- Core operands (core_code_o, core_key_o, core_mode_o) hold from the grant until the next grant.
- Minimum latency:
  - Grant at cycle 0, start at cycle 1, done sampled at cycle 2 at the earliest, rsp_valid_o at cycle 3.
  - Worst case: rsp_valid_o by cycle 2+TIMEOUT_CYC.
- x_valid_i dropping while not granted is legal and has no effect.
- Reset mid-operation: immediate return to IDLE, all outputs to reset values; the in-flight job is dropped with no response.
- No combinational path from core_done_i or rsp_ready_i to any output.

Optional Feature:
- Macro ENDEC_ARB_STATS_EN.
- When defined, three output ports are added, each CNT_W bits:
  - stat_a_o: completed responses for A.
  - stat_b_o: completed responses for B.
  - stat_to_o: timeouts.
- Counters increment on the RESP handshake, saturate at all-ones, and reset to 0.
- When undefined, the ports and counters are absent and behaviour is otherwise identical.

Test Plan:
- Single job: A sends code=0x5, key=0xA, mode=0; core model returns done 2 cycles after start with code=0xC. Required: a_ready_o for 1 cycle; core_start_o 1 cycle later; rsp_valid_o with code=0xC, id=0, err=0; start-to-rsp_valid = 3 cycles.
- Contention: A and B held valid for 4 jobs. Required grant order A, B, A, B, and rsp_id_o sequence 0, 1, 0, 1.
- Timeout: core never raises done, TIMEOUT_CYC=16. Required: rsp_valid_o exactly 17 cycles after core_start_o, with err=1, code=0x0.
- Backpressure: rsp_ready_i held low for 5 cycles in RESP. Required: rsp_valid_o and rsp fields stable; both ready outputs low; no second core_start_o.
- Reset in WAIT: assert rst_i 1 cycle after core_start_o. Required: all outputs 0 immediately; the next job after release is granted to A.
- Stats, with ENDEC_ARB_STATS_EN and CNT_W=2: 5 A jobs complete, 1 times out. Required stat_a_o=3 (saturated) and stat_to_o=1.
